ccip_c0_rd_arbiter: RTL and testbench
=====================================

Name: ccip_c0_rd_arbiter

Overview:
- Shares the CCI-P c0 read-request channel among N_REQ internal requesters using round-robin arbitration.
- Honours c0TxAlmFull and enforces a per-requester outstanding-read credit limit.
- Tags each request's mdata with the requester ID, and steers c0 read responses back to the owning requester.
- Sits between AFU read engines and the c0 Tx/Rx ports. Provides a drain sequence for quiescing before reset or power-state change.

Parameters:
- N_REQ, 4, number of requesters (1..16).
- MAX_OUT, 64, maximum outstanding reads per requester (1..255).
- TAG_W, 8, requester-private tag width carried in mdata[TAG_W-1:0] (TAG_W <= 12).

Ports:
- pClk  in  1  CCI-P interface clock.
- pck_cp2af_softReset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester read request valid.
- req_addr  in  N_REQ*42  per-requester cache-line address.
- req_tag  in  N_REQ*TAG_W  per-requester private tag.
- req_ready  out  N_REQ  request accepted this cycle (grant).
- c0TxAlmFull  in  1  c0 Tx almost-full from the FIU.
- c0tx_valid  out  1  c0 read request valid (registered).
- c0tx_addr  out  42  c0 request address.
- c0tx_mdata  out  16  {ID[3:0], zero pad, tag}.
- c0rx_rspValid  in  1  c0 read response valid.
- c0rx_mdata  in  16  response mdata.
- c0rx_data  in  512  response data.
- rsp_valid  out  N_REQ  one-hot response strobe to the owning requester.
- rsp_tag  out  TAG_W  returned tag.
- rsp_data  out  512  returned data.
- drain_req  in  1  level; request quiesce.
- drain_done  out  1  all credits returned while draining.
- err_rsp  out  1  sticky: response with an invalid ID, or underflow.

Behaviour:
- Reset values: all outputs 0; round-robin pointer = 0; all counts = 0; state = RUN.
- Eligibility for requester i: req_valid[i] && count[i] < MAX_OUT && !c0TxAlmFull && state == RUN.
- Grant selection:
  - Pick the first eligible requester at or after the pointer, wrapping modulo N_REQ.
  - req_ready[i] is combinational and at most one bit is set per cycle.
  - A request transfers when req_valid[i] && req_ready[i].
- On grant:
  - Next cycle, c0tx_valid = 1, c0tx_addr = req_addr[i], and c0tx_mdata = {i[3:0], zeros, req_tag[i]}. This is a one-cycle registered latency.
  - Pointer becomes (i+1) mod N_REQ. count[i] increments.
  - With no grant, c0tx_valid = 0 and the pointer is held.
- c0TxAlmFull: while it is asserted, no new grants are issued. A request already registered in the output still issues.
- Responses:
  - On c0rx_rspValid, decode id = c0rx_mdata[15:12].
  - If id < N_REQ: next cycle, rsp_valid[id] = 1, rsp_tag = c0rx_mdata[TAG_W-1:0], rsp_data = c0rx_data, and count[id] decrements.
  - If id >= N_REQ: the response is dropped, rsp_valid stays 0, and err_rsp sets.
  - If count[id] == 0 on a response: count stays 0, the response is still forwarded, and err_rsp sets.
- Simultaneous grant and response for the same requester: count is unchanged.
- Count at MAX_OUT: that requester is ineligible. A response arriving in the same cycle does not make it eligible until the next cycle, because eligibility uses the registered count.
- State machine:
  - RUN -> DRAIN when drain_req = 1. Grants stop immediately.
  - DRAIN -> DRAINED when all counts = 0 and c0tx_valid = 0.
  - DRAINED holds drain_done = 1. DRAINED -> RUN when drain_req = 0; drain_done clears on that same transition.
  - DRAIN -> RUN if drain_req drops before completion.
- Responses are processed in every state.
- err_rsp clears only on reset.
- Reset mid-operation: all counts, the pointer, state and outputs clear asynchronously. In-flight responses after reset are counted as underflow and set err_rsp.

Test Plan:
- Fairness: N_REQ = 4, all req_valid held, no almfull, no responses -> grants in order 0,1,2,3,0,... with a one-cycle gap to c0tx_valid; c0tx_mdata[15:12] matches the order.
- Backpressure: c0TxAlmFull = 1 for 5 cycles with requests pending -> no req_ready during that window, and at most 1 c0tx_valid after assertion; grants resume from the held pointer.
- Credit limit: MAX_OUT = 2, requester 1 alone valid, no responses -> exactly 2 grants, then req_ready[1] = 0. One response with mdata = 0x1005 -> rsp_valid = 0b0010 and rsp_tag = 0x05, then one more grant follows.
- Simultaneous events: requester 2 granted while a response for ID 2 arrives in the same cycle -> count[2] unchanged; next response -> rsp_valid[2] = 1.
- Errors: response mdata = 0x7000 with N_REQ = 4 -> dropped and err_rsp = 1. Response for ID 0 with count 0 -> forwarded, err_rsp stays 1, count stays 0.
- Drain: 3 outstanding reads, then assert drain_req -> no grants. After the third response, drain_done = 1 the next cycle. Deassert drain_req -> drain_done = 0 and grants resume.

Source files
------------

// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read-request channel among N_REQ requesters,
// with per-requester credit limits, mdata ID tagging, response steering and a drain sequence.
module ccip_c0_rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 64,
  parameter int TAG_W   = 8
) (
  input  logic                     pClk,
  input  logic                     pck_cp2af_softReset_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*42-1:0]      req_addr,
  input  logic [N_REQ*TAG_W-1:0]   req_tag,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     c0TxAlmFull,
  output logic                     c0tx_valid,
  output logic [41:0]              c0tx_addr,
  output logic [15:0]              c0tx_mdata,
  input  logic                     c0rx_rspValid,
  input  logic [15:0]              c0rx_mdata,
  input  logic [511:0]             c0rx_data,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [511:0]             rsp_data,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     err_rsp
);

  localparam int ID_W  = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q [N_REQ];
  logic [CNT_W-1:0]  count_d [N_REQ];
  logic              c0tx_valid_q, c0tx_valid_d;
  logic [41:0]       c0tx_addr_q, c0tx_addr_d;
  logic [15:0]       c0tx_mdata_q, c0tx_mdata_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [511:0]      rsp_data_q, rsp_data_d;
  logic              drain_done_q, drain_done_d;
  logic              err_q, err_d;

  logic              run_ok;
  logic [N_REQ-1:0]  elig;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [41:0]       sel_addr;
  logic [TAG_W-1:0]  sel_tag;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_hit;
  logic              underflow;
  logic              all_zero;

  always_comb begin : arbitrate
    // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
    run_ok    = (state_q == ST_RUN) && !drain_req && !c0TxAlmFull;
    elig      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    sel_addr  = '0;
    sel_tag   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = run_ok && req_valid[i] && (count_q[i] < CNT_W'(MAX_OUT));
    end
    // First pass covers requesters at or after the pointer; the second handles the wrap.
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_vld && elig[i] && (i >= int'(ptr_q))) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_vld && elig[i]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vld && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_addr     = req_addr[i*42 +: 42];
        sel_tag      = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin : next_state
    c0tx_valid_d = grant_vld;
    c0tx_addr_d  = grant_vld ? sel_addr : c0tx_addr_q;
    c0tx_mdata_d = c0tx_mdata_q;
    if (grant_vld) begin
      c0tx_mdata_d              = '0;
      c0tx_mdata_d[15:12]       = grant_idx;
      c0tx_mdata_d[TAG_W-1:0]   = sel_tag;
    end

    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end

    rsp_id      = c0rx_mdata[15:12];
    rsp_hit     = c0rx_rspValid && (int'(rsp_id) < N_REQ);
    rsp_valid_d = '0;
    underflow   = 1'b0;
    all_zero    = 1'b1;
    // An underflowing response leaves the count alone, but a same-cycle grant still counts.
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = rsp_hit && (rsp_id == ID_W'(i));
      underflow      = underflow | (rsp_valid_d[i] && (count_q[i] == '0));
      count_d[i]     = count_q[i]
                     + CNT_W'(grant_vld && (grant_idx == ID_W'(i)))
                     - CNT_W'(rsp_valid_d[i] && (count_q[i] != '0));
      all_zero       = all_zero & (count_d[i] == '0);
    end
    rsp_tag_d  = rsp_hit ? c0rx_mdata[TAG_W-1:0] : rsp_tag_q;
    rsp_data_d = rsp_hit ? c0rx_data : rsp_data_q;
    err_d      = err_q | (c0rx_rspValid && !rsp_hit) | underflow;

    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (!drain_req) state_d = ST_RUN;
                  else if (all_zero && !c0tx_valid_d) state_d = ST_DRAINED;
      ST_DRAINED: if (!drain_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
    drain_done_d = (state_d == ST_DRAINED);
  end

  // NOTE: the credit array is state the protocol depends on, so it is reset like every other flop.
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      state_q      <= ST_RUN;
      ptr_q        <= '0;
      for (int i = 0; i < N_REQ; i++) count_q[i] <= '0;
      c0tx_valid_q <= 1'b0;
      c0tx_addr_q  <= '0;
      c0tx_mdata_q <= '0;
      rsp_valid_q  <= '0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      for (int i = 0; i < N_REQ; i++) count_q[i] <= count_d[i];
      c0tx_valid_q <= c0tx_valid_d;
      c0tx_addr_q  <= c0tx_addr_d;
      c0tx_mdata_q <= c0tx_mdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_data_q   <= rsp_data_d;
      drain_done_q <= drain_done_d;
      err_q        <= err_d;
    end
  end

  assign c0tx_valid = c0tx_valid_q;
  assign c0tx_addr  = c0tx_addr_q;
  assign c0tx_mdata = c0tx_mdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_data   = rsp_data_q;
  assign drain_done = drain_done_q;
  assign err_rsp    = err_q;

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Bench for ccip_c0_rd_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the arbiter kept in this file.
module tb_ccip_c0_rd_arbiter;

  localparam int N  = 4;
  localparam int MO = 2;
  localparam int TW = 8;

  logic              pClk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N*42-1:0]   req_addr;
  logic [N*TW-1:0]   req_tag;
  logic [N-1:0]      req_ready;
  logic              c0TxAlmFull;
  logic              c0tx_valid;
  logic [41:0]       c0tx_addr;
  logic [15:0]       c0tx_mdata;
  logic              c0rx_rspValid;
  logic [15:0]       c0rx_mdata;
  logic [511:0]      c0rx_data;
  logic [N-1:0]      rsp_valid;
  logic [TW-1:0]     rsp_tag;
  logic [511:0]      rsp_data;
  logic              drain_req;
  logic              drain_done;
  logic              err_rsp;

  ccip_c0_rd_arbiter #(.N_REQ(N), .MAX_OUT(MO), .TAG_W(TW)) dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (rst_n),
    .req_valid             (req_valid),
    .req_addr              (req_addr),
    .req_tag               (req_tag),
    .req_ready             (req_ready),
    .c0TxAlmFull           (c0TxAlmFull),
    .c0tx_valid            (c0tx_valid),
    .c0tx_addr             (c0tx_addr),
    .c0tx_mdata            (c0tx_mdata),
    .c0rx_rspValid         (c0rx_rspValid),
    .c0rx_mdata            (c0rx_mdata),
    .c0rx_data             (c0rx_data),
    .rsp_valid             (rsp_valid),
    .rsp_tag               (rsp_tag),
    .rsp_data              (rsp_data),
    .drain_req             (drain_req),
    .drain_done            (drain_done),
    .err_rsp               (err_rsp)
  );

  always #5 pClk = ~pClk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding count per requester, pointer, drain phase (0 run, 1 drain, 2 drained).
  int           cnt [N];
  int           ptr;
  int           phase;
  logic         exp_tx_v;
  logic [41:0]  exp_addr;
  logic [15:0]  exp_md;
  logic [N-1:0] exp_rv;
  logic [TW-1:0] exp_tag;
  logic [511:0] exp_data;
  logic         exp_err;
  logic         exp_done;

  task automatic reset_model();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    ptr = 0; phase = 0;
    exp_tx_v = 0; exp_addr = '0; exp_md = '0;
    exp_rv = '0; exp_tag = '0; exp_data = '0;
    exp_err = 0; exp_done = 0;
  endtask

  always @(negedge pClk) begin : model
    int g, id, total_out;
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      reset_model();
    end else begin
      check("c0tx_valid", c0tx_valid, exp_tx_v);
      if (exp_tx_v) begin
        check("c0tx_addr", c0tx_addr, exp_addr);
        check("c0tx_mdata", c0tx_mdata, exp_md);
      end
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 0) begin
        check("rsp_tag", rsp_tag, exp_tag);
        check("rsp_data", rsp_data, exp_data);
      end
      check("err_rsp", err_rsp, exp_err);
      check("drain_done", drain_done, exp_done);

      g = -1;
      if (phase == 0 && !drain_req && !c0TxAlmFull) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(ptr + k) % N] && cnt[(ptr + k) % N] < MO) g = (ptr + k) % N;
        end
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      check("req_ready", req_ready, exp_rdy);

      exp_tx_v = (g >= 0);
      if (g >= 0) begin
        exp_addr = req_addr[g*42 +: 42];
        exp_md   = 16'((g << 12) | int'(req_tag[g*TW +: TW]));
        ptr      = (g + 1) % N;
      end
      exp_rv = '0;
      if (c0rx_rspValid) begin
        id = int'(c0rx_mdata[15:12]);
        if (id < N) begin
          exp_rv   = N'(1 << id);
          exp_tag  = c0rx_mdata[TW-1:0];
          exp_data = c0rx_data;
          if (cnt[id] == 0) exp_err = 1;
          else cnt[id]--;
        end else begin
          exp_err = 1;
        end
      end
      if (g >= 0) cnt[g]++;

      total_out = 0;
      for (int i = 0; i < N; i++) total_out += cnt[i];
      case (phase)
        0: if (drain_req) phase = 1;
        1: if (!drain_req) phase = 0;
           else if (total_out == 0 && !exp_tx_v) phase = 2;
        default: if (!drain_req) phase = 0;
      endcase
      exp_done = (phase == 2);
    end
  end

  task automatic cyc();
    @(posedge pClk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; c0TxAlmFull = 0; c0rx_rspValid = 0; drain_req = 0;
  endtask

  task automatic rand_req_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*42 +: 42] = 42'({$urandom, $urandom});
      req_tag[i*TW +: TW]  = TW'($urandom);
    end
  endtask

  task automatic drive_rsp(input logic [15:0] md);
    c0rx_rspValid = 1;
    c0rx_mdata    = md;
    for (int w = 0; w < 16; w++) c0rx_data[w*32 +: 32] = $urandom;
  endtask

  function automatic int outstanding();
    int s = 0;
    for (int i = 0; i < N; i++) s += cnt[i];
    return s;
  endfunction

  // Return every credit the model believes is outstanding, bounded in cycles.
  task automatic return_all();
    int guard = 0;
    req_valid = '0;
    c0rx_rspValid = 0;
    cyc();
    while (outstanding() > 0 && guard < 100) begin
      for (int i = N - 1; i >= 0; i--) if (cnt[i] > 0) drive_rsp(16'((i << 12) | ($urandom & 'hff)));
      cyc();
      guard++;
    end
    if (guard >= 100) begin
      total++; bad++;
      $display("FAIL return_all: credits still outstanding after %0d cycles", guard);
    end
    c0rx_rspValid = 0;
    cyc();
  endtask

  initial begin : stim
    int txc;
    idle();
    req_addr = '0; req_tag = '0; c0rx_mdata = '0; c0rx_data = '0;
    rst_n = 0;
    repeat (2) @(posedge pClk);
    #1;
    check("rst_c0tx_valid", c0tx_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_err", err_rsp, 0);
    check("rst_drain_done", drain_done, 0);
    rst_n = 1;
    cyc();

    // Fairness: grants rotate 0,1,2,3,0 with c0tx one cycle later.
    rand_req_fields();
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge pClk);
      check("fair_ready", req_ready, 1 << (k % 4));
      if (k > 0) begin
        check("fair_txv", c0tx_valid, 1);
        check("fair_id", c0tx_mdata[15:12], (k - 1) % 4);
      end else begin
        check("fair_gap", c0tx_valid, 0);
      end
      cyc();
    end
    return_all();

    // Backpressure: pointer is at 1, so grant 1, then hold 5 cycles, then resume at 2.
    req_valid = '1;
    @(negedge pClk);
    check("bp_pre", req_ready, 4'b0010);
    cyc();
    c0TxAlmFull = 1;
    txc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge pClk);
      check("bp_ready", req_ready, 0);
      if (c0tx_valid) txc++;
      cyc();
    end
    check("bp_tx_count", txc, 1);
    c0TxAlmFull = 0;
    @(negedge pClk);
    check("bp_resume", req_ready, 4'b0100);
    cyc();
    return_all();

    // Credit limit on requester 1.
    req_valid = 4'b0010;
    @(negedge pClk); check("credit_g1", req_ready, 4'b0010); cyc();
    @(negedge pClk); check("credit_g2", req_ready, 4'b0010); cyc();
    @(negedge pClk); check("credit_block", req_ready, 0); cyc();
    drive_rsp(16'h1005);
    @(negedge pClk); check("credit_same_cycle", req_ready, 0); cyc();
    c0rx_rspValid = 0;
    @(negedge pClk);
    check("credit_rsp_valid", rsp_valid, 4'b0010);
    check("credit_rsp_tag", rsp_tag, 8'h05);
    check("credit_regrant", req_ready, 4'b0010);
    cyc();
    @(negedge pClk); check("credit_reblock", req_ready, 0);
    return_all();

    // Simultaneous grant and response for requester 2.
    req_valid = 4'b0100;
    @(negedge pClk); check("sim_g1", req_ready, 4'b0100); cyc();
    drive_rsp(16'h2022);
    @(negedge pClk); check("sim_g2", req_ready, 4'b0100); cyc();
    c0rx_rspValid = 0;
    @(negedge pClk);
    check("sim_rsp", rsp_valid, 4'b0100);
    check("sim_g3", req_ready, 4'b0100);
    cyc();
    @(negedge pClk); check("sim_block", req_ready, 0);
    req_valid = '0;
    drive_rsp(16'h2023);
    cyc();
    c0rx_rspValid = 0;
    @(negedge pClk); check("sim_next_rsp", rsp_valid, 4'b0100);
    return_all();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rand_req_fields();
      req_valid   = N'($urandom);
      c0TxAlmFull = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 29) == 0) drain_req = ~drain_req;
      c0rx_rspValid = 0;
      if ($urandom_range(0, 4) < 2 && outstanding() > 0) begin
        int id = $urandom_range(0, N - 1);
        for (int t = 0; t < N && cnt[id] == 0; t++) id = (id + 1) % N;
        drive_rsp(16'((id << 12) | ($urandom & 'hff)));
      end
      cyc();
    end
    idle();
    return_all();

    // Drain with three outstanding reads.
    req_valid = 4'b0111;
    repeat (3) cyc();
    drain_req = 1;
    @(negedge pClk); check("drain_block", req_ready, 0); cyc();
    req_valid = 4'b0111;
    for (int r = 0; r < 3; r++) begin
      drive_rsp(16'((r << 12) | 'h40));
      @(negedge pClk); check("drain_pending", drain_done, 0);
      cyc();
    end
    c0rx_rspValid = 0;
    @(negedge pClk);
    check("drain_done_set", drain_done, 1);
    check("drain_no_grant", req_ready, 0);
    cyc();
    drain_req = 0;
    cyc();
    @(negedge pClk);
    check("drain_done_clr", drain_done, 0);
    check("drain_resume", req_ready != 0, 1);
    return_all();

    // Error responses.
    drive_rsp(16'h7000);
    @(negedge pClk); check("err_before", err_rsp, 0); cyc();
    c0rx_rspValid = 0;
    @(negedge pClk);
    check("err_drop_rv", rsp_valid, 0);
    check("err_bad_id", err_rsp, 1);
    drive_rsp(16'h0033);
    cyc();
    c0rx_rspValid = 0;
    @(negedge pClk);
    check("err_uf_fwd", rsp_valid, 4'b0001);
    check("err_uf_tag", rsp_tag, 8'h33);
    check("err_sticky", err_rsp, 1);
    cyc();

    // Reset mid-operation, then a stale in-flight response.
    req_valid = '1;
    cyc();
    #2;
    rst_n = 0;
    #1;
    check("mrst_txv", c0tx_valid, 0);
    check("mrst_err", err_rsp, 0);
    check("mrst_rv", rsp_valid, 0);
    check("mrst_done", drain_done, 0);
    req_valid = '0;
    @(negedge pClk);
    cyc();
    rst_n = 1;
    cyc();
    drive_rsp(16'h0011);
    cyc();
    c0rx_rspValid = 0;
    @(negedge pClk);
    check("stale_fwd", rsp_valid, 4'b0001);
    check("stale_err", err_rsp, 1);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
